iomem_gpio_bank: RTL and testbench
==================================

IOMEM_GPIO_BANK -- requirements
Module: iomem_gpio_bank

Interface
REQ-001 Parameter WIDTH, default 8, number of GPIO pins; legal range 1..32.
REQ-002 Parameter ADDR_HI, default 8'h03, value matched against iomem_addr[31:24] for block select.
REQ-003 clk  input  1  system clock; all state updates on posedge clk.
REQ-004 resetn  input  1  reset; synchronous, active-low.
REQ-005 iomem_valid  input  1  bus request valid.
REQ-006 iomem_ready  output  1  one-cycle acknowledge pulse.
REQ-007 iomem_wstrb  input  4  byte write strobes; all zero means read.
REQ-008 iomem_addr  input  32  byte address.
REQ-009 iomem_wdata  input  32  write data.
REQ-010 iomem_rdata  output  32  read data, registered.
REQ-011 gpio_in  input  WIDTH  asynchronous pin inputs.
REQ-012 gpio_out  output  WIDTH  pin output values (OUT register).
REQ-013 gpio_oe  output  WIDTH  pin output enables (OE register); 1 = drive.
REQ-014 irq  output  1  level interrupt, registered.

Function
REQ-015 The block SHALL be selected when iomem_valid=1, iomem_ready=0 and iomem_addr[31:24]==ADDR_HI.
- On select: iomem_ready=1 at the next edge for exactly one cycle.
- Otherwise: iomem_ready=0.
REQ-016 Register index = iomem_addr[4:2]; iomem_addr[23:5] and [1:0] SHALL be ignored.
- 0: OUT, R/W.
- 1: OE, R/W.
- 2: IN, RO (synchronised pins).
- 3: IRQ_MASK, R/W.
- 4: IRQ_PEND, R/W1C.
- 5-7: read 0, writes ignored.
REQ-017 Writes SHALL apply per byte lane where iomem_wstrb[n]=1, on the same edge that asserts iomem_ready.
REQ-018 iomem_rdata SHALL capture the pre-write value of the addressed register on the select edge; bits [31:WIDTH] SHALL read 0.
REQ-019 iomem_rdata SHALL hold its value when the block is not selected.
REQ-020 Register bits at or above WIDTH SHALL not exist; writes to them are discarded.
REQ-021 Each gpio_in bit SHALL pass through a two-flop synchroniser; the IN register is the second flop.
- A pin change SHALL be readable via IN at the third edge after the change.
REQ-022 A per-bit previous-value flop SHALL sample IN each cycle.
- Rising edge = IN & ~prev.
- A rising edge sets the IRQ_PEND bit regardless of IRQ_MASK.
REQ-023 A W1C write SHALL clear IRQ_PEND bits whose wdata bit is 1 in an enabled byte lane.
- If a rising edge and a W1C clear hit the same bit on the same edge, set SHALL win.
REQ-024 irq SHALL be registered: irq <= |(IRQ_PEND & IRQ_MASK), evaluated on the next-state values, so irq follows a pend/mask change by one edge.
REQ-025 Back-to-back requests SHALL be accepted no faster than every second cycle, because the select requires iomem_ready=0.

Reset
REQ-026 While resetn=0 at an edge, the following SHALL clear to 0: OUT, OE, IRQ_MASK, IRQ_PEND, synchroniser flops, prev flops, iomem_ready, iomem_rdata and irq.
REQ-027 A bus request in flight during reset SHALL be dropped; no ready pulse SHALL be produced for it.
REQ-028 A pin held high through reset release SHALL register one rising edge in IRQ_PEND at the third edge after release; IRQ_MASK=0 keeps irq low.

Configuration
REQ-029 Macro GPIO_BANK_IRQ_EN SHALL select whether the interrupt logic is built.
- Defined: edge detection, IRQ_MASK, IRQ_PEND and irq are built as specified.
- Undefined: prev flops, IRQ_MASK and IRQ_PEND are not built; indices 3-4 read 0 and ignore writes; irq is tied 0.
- The bus and the OUT/OE/IN registers SHALL be identical in both builds.

Verification
REQ-030 WIDTH=8, write 0x000000A5 with wstrb=4'b0001 to 0x03000000 -> one-cycle ready; gpio_out=0xA5; read back returns 0x000000A5.
REQ-031 Write 0xFFFFFFFF to OE with wstrb=4'b0010 (WIDTH=8) -> gpio_oe unchanged at 0x00; write with wstrb=4'b0001 -> gpio_oe=0xFF; read returns 0x000000FF.
REQ-032 gpio_in 0x00->0x04 -> IN reads 0x04 from the third edge; IRQ_PEND=0x04; with IRQ_MASK=0x04, irq=1 one edge later.
REQ-033 W1C 0x04 to IRQ_PEND on the same edge as a new bit-2 rising edge -> IRQ_PEND stays 0x04 and irq stays 1; a later W1C with no edge -> IRQ_PEND=0 and irq=0 one edge later.
REQ-034 Request with addr[31:24]=0x04 -> no ready and rdata unchanged; reset asserted while iomem_valid is held -> no ready and all outputs 0.
REQ-035 Build without GPIO_BANK_IRQ_EN, toggle pins and write 0xFF to index 3 -> index 3 and 4 read 0; irq stays 0.

Source files
------------

// File: rtl/iomem_gpio_bank.sv
`default_nettype none
// ============================================================================
// Module   : iomem_gpio_bank
// Brief    : GPIO bank on the iomem bus with OUT/OE/IN registers and an
//            optional rising-edge interrupt block (macro GPIO_BANK_IRQ_EN).
// Revision : 1.0 - initial release
// ============================================================================
module iomem_gpio_bank #(
    parameter int         WIDTH   = 8,
    parameter logic [7:0] ADDR_HI = 8'h03
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             iomem_valid,
    output logic             iomem_ready,
    input  logic [3:0]       iomem_wstrb,
    input  logic [31:0]      iomem_addr,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [2:0] c_IDX_OUT = 3'd0;
    localparam logic [2:0] c_IDX_OE  = 3'd1;
    localparam logic [2:0] c_IDX_IN  = 3'd2;

    logic             w_sel;
    logic             w_we;
    logic [2:0]       w_idx;
    logic [31:0]      w_lane;
    logic [WIDTH-1:0] w_wm;
    logic [WIDTH-1:0] w_wd;
    logic [31:0]      w_rd;

    logic             r_ready;
    logic [31:0]      r_rdata;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_oe;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_in;

    // Address bits outside [31:24] and [4:2], and data above WIDTH, are don't-care.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, iomem_addr, iomem_wdata};

    assign w_sel  = iomem_valid && !r_ready && (iomem_addr[31:24] == ADDR_HI);
    assign w_we   = w_sel && (iomem_wstrb != 4'b0000);
    assign w_idx  = iomem_addr[4:2];
    assign w_lane = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                     {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    assign w_wm   = w_lane[WIDTH-1:0];
    assign w_wd   = iomem_wdata[WIDTH-1:0];

`ifdef GPIO_BANK_IRQ_EN
    localparam logic [2:0] c_IDX_MASK = 3'd3;
    localparam logic [2:0] c_IDX_PEND = 3'd4;

    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_pend;
    logic             r_irq;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_mask_nxt;
    logic [WIDTH-1:0] w_pend_nxt;

    // A rising edge overrides a simultaneous W1C on the same bit.
    always_comb begin
        w_rise     = r_in & ~r_prev;
        w_clr      = '0;
        w_mask_nxt = r_mask;
        if (w_we && (w_idx == c_IDX_MASK)) begin
            w_mask_nxt = (r_mask & ~w_wm) | (w_wd & w_wm);
        end
        if (w_we && (w_idx == c_IDX_PEND)) begin
            w_clr = w_wd & w_wm;
        end
        w_pend_nxt = (r_pend & ~w_clr) | w_rise;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_prev <= '0;
            r_mask <= '0;
            r_pend <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_prev <= r_in;
            r_mask <= w_mask_nxt;
            r_pend <= w_pend_nxt;
            r_irq  <= |(w_pend_nxt & w_mask_nxt);
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        w_rd = '0;
        case (w_idx)
            c_IDX_OUT:  w_rd[WIDTH-1:0] = r_out;
            c_IDX_OE:   w_rd[WIDTH-1:0] = r_oe;
            c_IDX_IN:   w_rd[WIDTH-1:0] = r_in;
`ifdef GPIO_BANK_IRQ_EN
            c_IDX_MASK: w_rd[WIDTH-1:0] = r_mask;
            c_IDX_PEND: w_rd[WIDTH-1:0] = r_pend;
`endif
            default:    w_rd = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_out   <= '0;
            r_oe    <= '0;
            r_sync  <= '0;
            r_in    <= '0;
        end else begin
            r_sync  <= gpio_in;
            r_in    <= r_sync;
            r_ready <= w_sel;
            if (w_sel) begin
                r_rdata <= w_rd;
            end
            if (w_we && (w_idx == c_IDX_OUT)) begin
                r_out <= (r_out & ~w_wm) | (w_wd & w_wm);
            end
            if (w_we && (w_idx == c_IDX_OE)) begin
                r_oe <= (r_oe & ~w_wm) | (w_wd & w_wm);
            end
        end
    end

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign gpio_out    = r_out;
    assign gpio_oe     = r_oe;

endmodule
`default_nettype wire

// File: tb/tb_iomem_gpio_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_iomem_gpio_bank
// Brief    : Randomised self-checking bench for iomem_gpio_bank (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_iomem_gpio_bank;

    localparam int W = 8;
`ifdef GPIO_BANK_IRQ_EN
    localparam bit IRQ_BUILT = 1'b1;
`else
    localparam bit IRQ_BUILT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         iomem_valid = 1'b0;
    logic         iomem_ready;
    logic [3:0]   iomem_wstrb = 4'b0;
    logic [31:0]  iomem_addr = 32'h0;
    logic [31:0]  iomem_wdata = 32'h0;
    logic [31:0]  iomem_rdata;
    logic [W-1:0] gpio_in = '0;
    logic [W-1:0] gpio_out;
    logic [W-1:0] gpio_oe;
    logic         irq;

    int checks = 0;
    int errors = 0;

    // Reference state: register contents as the bus sees them once pins have settled.
    logic [W-1:0] m_out  = '0;
    logic [W-1:0] m_oe   = '0;
    logic [W-1:0] m_mask = '0;
    logic [W-1:0] m_pend = '0;
    logic [W-1:0] m_pins = '0;

    always #5 clk = ~clk;

    iomem_gpio_bank #(.WIDTH(W), .ADDR_HI(8'h03)) dut (
        .clk(clk), .resetn(resetn),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    function automatic logic [31:0] m_read(input int idx);
        logic [31:0] r;
        r = '0;
        case (idx)
            0: r[W-1:0] = m_out;
            1: r[W-1:0] = m_oe;
            2: r[W-1:0] = m_pins;
            3: r[W-1:0] = IRQ_BUILT ? m_mask : '0;
            4: r[W-1:0] = IRQ_BUILT ? m_pend : '0;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic m_irq();
        return IRQ_BUILT && ((m_pend & m_mask) != '0);
    endfunction

    task automatic m_write(input int idx, input logic [3:0] s, input logic [31:0] d);
        logic [31:0]  lanes;
        logic [W-1:0] m;
        lanes = '0;
        for (int n = 0; n < 4; n++) if (s[n]) lanes[n*8 +: 8] = 8'hFF;
        m = lanes[W-1:0];
        case (idx)
            0: m_out  = (m_out  & ~m) | (d[W-1:0] & m);
            1: m_oe   = (m_oe   & ~m) | (d[W-1:0] & m);
            3: m_mask = (m_mask & ~m) | (d[W-1:0] & m);
            4: m_pend = m_pend & ~(d[W-1:0] & m);
            default: ;
        endcase
    endtask

    task automatic m_pins_change(input logic [W-1:0] p);
        m_pend = m_pend | (p & ~m_pins);
        m_pins = p;
    endtask

    // One bus request; waits at most 4 edges for the acknowledge.
    task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       output logic got, output logic [31:0] rd);
        got = 1'b0;
        rd  = '0;
        @(negedge clk);
        iomem_valid = 1'b1; iomem_addr = a; iomem_wstrb = s; iomem_wdata = d;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk); #1;
            if (iomem_ready) begin
                got = 1'b1;
                rd  = iomem_rdata;
            end
        end
        iomem_valid = 1'b0; iomem_wstrb = 4'b0;
    endtask

    function automatic logic [31:0] reg_addr(input int idx);
        return {8'h03, 19'h0, idx[2:0], 2'b00};
    endfunction

    task automatic test_reset();
        logic got; logic [31:0] rd;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({iomem_ready, irq} !== 2'b00) begin errors++; $display("FAIL reset_ready_irq got=%b exp=00", {iomem_ready, irq}); end
        checks++; if (iomem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", iomem_rdata); end
        checks++; if ({gpio_out, gpio_oe} !== '0) begin errors++; $display("FAIL reset_out_oe got=%h exp=0", {gpio_out, gpio_oe}); end
        @(negedge clk); resetn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus(reg_addr(i), 4'b0, 32'h0, got, rd);
            checks++; if (!got || rd !== 32'h0) begin errors++; $display("FAIL reset_read_idx%0d got=%b/%h exp=1/0", i, got, rd); end
        end
    endtask

    task automatic test_out_write();
        logic got; logic [31:0] rd;
        bus(32'h0300_0000, 4'b0001, 32'h0000_00A5, got, rd);
        m_write(0, 4'b0001, 32'h0000_00A5);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL out_wr_ready got=%b exp=1", got); end
        @(posedge clk); #1;
        checks++; if (iomem_ready !== 1'b0) begin errors++; $display("FAIL out_ready_pulse got=%b exp=0", iomem_ready); end
        checks++; if (gpio_out !== m_out) begin errors++; $display("FAIL out_value got=%h exp=%h", gpio_out, m_out); end
        bus(32'h0300_0000, 4'b0, 32'h0, got, rd);
        checks++; if (rd !== m_read(0)) begin errors++; $display("FAIL out_readback got=%h exp=%h", rd, m_read(0)); end
    endtask

    task automatic test_oe_lanes();
        logic got; logic [31:0] rd;
        bus(reg_addr(1), 4'b0010, 32'hFFFF_FFFF, got, rd);
        m_write(1, 4'b0010, 32'hFFFF_FFFF);
        checks++; if (gpio_oe !== m_oe) begin errors++; $display("FAIL oe_upper_lane got=%h exp=%h", gpio_oe, m_oe); end
        bus(reg_addr(1), 4'b0001, 32'hFFFF_FFFF, got, rd);
        m_write(1, 4'b0001, 32'hFFFF_FFFF);
        checks++; if (gpio_oe !== m_oe) begin errors++; $display("FAIL oe_low_lane got=%h exp=%h", gpio_oe, m_oe); end
        bus(32'h03FF_FFE5, 4'b0, 32'h0, got, rd);
        checks++; if (rd !== m_read(1)) begin errors++; $display("FAIL oe_alias_read got=%h exp=%h", rd, m_read(1)); end
    endtask

    task automatic test_addr_decode();
        logic got; logic [31:0] rd; logic [31:0] prev;
        prev = iomem_rdata;
        bus(32'h0400_0000, 4'b1111, 32'h0000_005A, got, rd);
        checks++; if (got !== 1'b0) begin errors++; $display("FAIL decode_foreign_ready got=%b exp=0", got); end
        checks++; if (iomem_rdata !== prev || gpio_out !== m_out) begin errors++; $display("FAIL decode_foreign_state got=%h/%h exp=%h/%h", iomem_rdata, gpio_out, prev, m_out); end
        bus(reg_addr(5), 4'b1111, 32'hFFFF_FFFF, got, rd);
        bus(reg_addr(5), 4'b0, 32'h0, got, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL decode_reserved got=%h exp=0", rd); end
    endtask

    task automatic test_back_to_back();
        int pulses; logic last; logic dbl;
        pulses = 0; last = 1'b0; dbl = 1'b0;
        @(posedge clk);
        @(negedge clk);
        iomem_valid = 1'b1; iomem_addr = reg_addr(0); iomem_wstrb = 4'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (iomem_ready) pulses++;
            if (iomem_ready && last) dbl = 1'b1;
            last = iomem_ready;
        end
        iomem_valid = 1'b0;
        checks++; if (pulses != 4 || dbl) begin errors++; $display("FAIL b2b_pulses got=%0d dbl=%b exp=4 dbl=0", pulses, dbl); end
        checks++; if (iomem_rdata !== m_read(0)) begin errors++; $display("FAIL b2b_rdata got=%h exp=%h", iomem_rdata, m_read(0)); end
    endtask

    task automatic test_in_sync();
        logic got; logic [31:0] rd;
        @(negedge clk); gpio_in = 8'h04;
        bus(reg_addr(2), 4'b0, 32'h0, got, rd);
        checks++; if (rd !== m_read(2)) begin errors++; $display("FAIL in_too_early got=%h exp=%h", rd, m_read(2)); end
        m_pins_change(8'h04);
        repeat (3) @(posedge clk);
        @(negedge clk); gpio_in = 8'h0C;
        @(posedge clk); @(posedge clk);
        bus(reg_addr(2), 4'b0, 32'h0, got, rd);
        m_pins_change(8'h0C);
        checks++; if (rd !== m_read(2)) begin errors++; $display("FAIL in_third_edge got=%h exp=%h", rd, m_read(2)); end
        bus(reg_addr(4), 4'b0, 32'h0, got, rd);
        checks++; if (rd !== m_read(4)) begin errors++; $display("FAIL in_pend got=%h exp=%h", rd, m_read(4)); end
        bus(reg_addr(3), 4'b0001, 32'h0000_0004, got, rd);
        m_write(3, 4'b0001, 32'h0000_0004);
        @(posedge clk); #1;
        checks++; if (irq !== m_irq()) begin errors++; $display("FAIL in_irq got=%b exp=%b", irq, m_irq()); end
    endtask

    task automatic test_w1c_collision();
        logic got; logic [31:0] rd; logic [31:0] pre;
        @(negedge clk); gpio_in = 8'h00;
        m_pins_change(8'h00);
        repeat (5) @(posedge clk);
        @(negedge clk); gpio_in = 8'h04;
        @(posedge clk); @(posedge clk);
        pre = m_read(4);
        bus(reg_addr(4), 4'b0001, 32'h0000_0004, got, rd);
        m_write(4, 4'b0001, 32'h0000_0004);
        m_pins_change(8'h04);
        checks++; if (rd !== pre) begin errors++; $display("FAIL w1c_prewrite got=%h exp=%h", rd, pre); end
        @(posedge clk); #1;
        checks++; if (irq !== m_irq()) begin errors++; $display("FAIL w1c_set_wins_irq got=%b exp=%b", irq, m_irq()); end
        bus(reg_addr(4), 4'b0, 32'h0, got, rd);
        checks++; if (rd !== m_read(4)) begin errors++; $display("FAIL w1c_set_wins_pend got=%h exp=%h", rd, m_read(4)); end
        bus(reg_addr(4), 4'b0001, 32'h0000_0004, got, rd);
        m_write(4, 4'b0001, 32'h0000_0004);
        @(posedge clk); #1;
        checks++; if (irq !== m_irq()) begin errors++; $display("FAIL w1c_clear_irq got=%b exp=%b", irq, m_irq()); end
        bus(reg_addr(4), 4'b0, 32'h0, got, rd);
        checks++; if (rd !== m_read(4)) begin errors++; $display("FAIL w1c_clear_pend got=%h exp=%h", rd, m_read(4)); end
    endtask

    task automatic test_idx34();
        logic got; logic [31:0] rd;
        bus(reg_addr(3), 4'b0001, 32'h0000_00FF, got, rd);
        m_write(3, 4'b0001, 32'h0000_00FF);
        bus(reg_addr(3), 4'b0, 32'h0, got, rd);
        checks++; if (rd !== m_read(3)) begin errors++; $display("FAIL idx3_read got=%h exp=%h", rd, m_read(3)); end
        bus(reg_addr(4), 4'b0, 32'h0, got, rd);
        checks++; if (rd !== m_read(4)) begin errors++; $display("FAIL idx4_read got=%h exp=%h", rd, m_read(4)); end
        @(posedge clk); #1;
        checks++; if (irq !== m_irq()) begin errors++; $display("FAIL idx34_irq got=%b exp=%b", irq, m_irq()); end
    endtask

    task automatic test_reset_inflight();
        logic got; logic [31:0] rd;
        bus(reg_addr(0), 4'b0, 32'h0, got, rd);
        @(negedge clk);
        iomem_valid = 1'b1; iomem_addr = reg_addr(0); iomem_wstrb = 4'b0;
        resetn = 1'b0; gpio_in = 8'h84;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++; if (iomem_ready !== 1'b0) begin errors++; $display("FAIL rst_inflight_ready cyc=%0d got=%b exp=0", i, iomem_ready); end
        end
        checks++; if ({iomem_rdata, gpio_out, gpio_oe, irq} !== '0) begin errors++; $display("FAIL rst_outputs got=%h/%h/%h/%b exp=0", iomem_rdata, gpio_out, gpio_oe, irq); end
        m_out = '0; m_oe = '0; m_mask = '0; m_pend = '0; m_pins = '0;
        @(negedge clk); iomem_valid = 1'b0; resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (irq !== 1'b0 || iomem_ready !== 1'b0) begin errors++; $display("FAIL rst_release cyc=%0d irq=%b ready=%b exp=0/0", i, irq, iomem_ready); end
        end
        m_pins_change(8'h84);
        bus(reg_addr(4), 4'b0, 32'h0, got, rd);
        checks++; if (rd !== m_read(4)) begin errors++; $display("FAIL rst_held_pin_pend got=%h exp=%h", rd, m_read(4)); end
    endtask

    task automatic test_random();
        logic got; logic [31:0] rd; logic [31:0] pre; logic [31:0] prev_rd;
        logic [31:0] a; logic [3:0] s; logic [31:0] d; int idx; logic foreign;
        logic [W-1:0] p;
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                p = W'($urandom);
                @(negedge clk); gpio_in = p;
                m_pins_change(p);
                repeat (4) @(posedge clk);
            end
            idx     = $urandom_range(0, 7);
            s       = ($urandom_range(0, 9) < 4) ? 4'b0 : 4'($urandom);
            d       = $urandom;
            foreign = ($urandom_range(0, 9) == 0);
            a       = {foreign ? 8'h05 : 8'h03, 19'($urandom), idx[2:0], 2'($urandom)};
            pre     = m_read(idx);
            prev_rd = iomem_rdata;
            bus(a, s, d, got, rd);
            if (foreign) begin
                checks++; if (got !== 1'b0 || iomem_rdata !== prev_rd) begin errors++; $display("FAIL rnd_foreign t=%0d got=%b rdata=%h exp=0/%h", t, got, iomem_rdata, prev_rd); end
            end else begin
                m_write(idx, s, d);
                checks++; if (got !== 1'b1 || rd !== pre) begin errors++; $display("FAIL rnd_read t=%0d idx=%0d got=%b/%h exp=1/%h", t, idx, got, rd, pre); end
            end
            @(posedge clk); #1;
            checks++; if (gpio_out !== m_out || gpio_oe !== m_oe || irq !== m_irq()) begin
                errors++;
                $display("FAIL rnd_state t=%0d out=%h oe=%h irq=%b exp=%h/%h/%b", t, gpio_out, gpio_oe, irq, m_out, m_oe, m_irq());
            end
        end
    endtask

    initial begin
        test_reset();
        test_out_write();
        test_oe_lanes();
        test_addr_decode();
        test_back_to_back();
        test_in_sync();
        test_w1c_collision();
        test_idx34();
        test_reset_inflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
